// File: rtl/hdmi_video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// hdmi_video_timing_gen_if
// Pixel request/valid handshake between the 256->24 width adapter (master)
// and the HDMI video timing generator (slave).
//   pix_data  : 24-bit RGB pixel, master -> slave
//   pix_valid : pix_data valid this cycle, master -> slave
//   pix_req   : one pixel requested this cycle, slave -> master
// ---------------------------------------------------------------------------
interface hdmi_video_timing_gen_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_req;

    modport master (output pix_data, output pix_valid, input pix_req);
    modport slave  (input pix_data, input pix_valid, output pix_req);
endinterface

// File: rtl/hdmi_video_timing_gen.sv
// ---------------------------------------------------------------------------
// hdmi_video_timing_gen
// Pulls 24-bit pixels from the width adapter into a small FIFO and plays them
// out on a CEA-style raster (DE/HSYNC/VSYNC) towards the HDMI transmitter.
// Ports:
//   tx_clock, tx_rst_n : pixel clock, async active-low reset
//   enable             : level, start/stop video (stop takes effect at frame end)
//   pix_if (slave)     : pix_data/pix_valid in, pix_req out
//   vid_data/de/hsync/vsync : registered pixel bus to the HDMI TX
//   frame_start        : pulse with the first DE of a frame
//   underflow/overflow : sticky error flags, cleared by reset only
// ---------------------------------------------------------------------------
module hdmi_video_timing_gen #(
    parameter int          H_ACTIVE   = 1920,
    parameter int          H_FP       = 88,
    parameter int          H_SYNC     = 44,
    parameter int          H_BP       = 148,
    parameter int          V_ACTIVE   = 1080,
    parameter int          V_FP       = 4,
    parameter int          V_SYNC     = 5,
    parameter int          V_BP       = 36,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int          FIFO_DEPTH = 64,
    parameter int          REQ_MARGIN = 8,
    parameter int          PREFILL    = 32,
    parameter logic [23:0] UF_COLOR   = 24'hFF00FF
) (
    input  logic                          tx_clock,
    input  logic                          tx_rst_n,
    input  logic                          enable,
    hdmi_video_timing_gen_if.slave        pix_if,
    output logic [23:0]                   vid_data,
    output logic                          vid_de,
    output logic                          vid_hsync,
    output logic                          vid_vsync,
    output logic                          frame_start,
    output logic                          underflow,
    output logic                          overflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CW-1:0] DEPTH_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] REQ_LVL   = CW'(FIFO_DEPTH - REQ_MARGIN);
    localparam logic [CW-1:0] PF_LVL    = CW'(PREFILL);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_used;
    logic [23:0]   mem [FIFO_DEPTH];

    logic running, active, hs_act, vs_act, last_pix;
    logic full, empty, push, pop, drop, flush;

    assign running  = (state == S_RUN);
    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_act   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_act   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    assign full  = (fifo_used == DEPTH_LVL);
    assign empty = (fifo_used == '0);
    // Input is only listened to once the block has been enabled.
    assign push  = pix_if.pix_valid && (state != S_IDLE) && !full;
    assign drop  = pix_if.pix_valid && (state != S_IDLE) && full;
    // Raster never stalls: an active cycle with nothing buffered shows UF_COLOR.
    assign pop   = running && active && !empty;
    // Stopping only happens on the last cycle of a frame; leftovers are discarded.
    assign flush = running && last_pix && !enable;

    // Storage has no reset; only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge tx_clock) begin
        if (push) mem[wr_ptr] <= pix_if.pix_data;
    end

    always_ff @(posedge tx_clock or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state          <= S_IDLE;
            h_cnt          <= '0;
            v_cnt          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_used      <= '0;
            pix_if.pix_req <= 1'b0;
            vid_data       <= '0;
            vid_de         <= 1'b0;
            vid_hsync      <= ~HS_POL;
            vid_vsync      <= ~VS_POL;
            frame_start    <= 1'b0;
            underflow      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            // Pixel FIFO bookkeeping; flush wins over a same-cycle push.
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                fifo_used <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fifo_used <= fifo_used + CW'(1);
                    2'b01:   fifo_used <= fifo_used - CW'(1);
                    default: ;
                endcase
            end
            if (drop) overflow <= 1'b1;

            // Request while there is room for the pixels still in flight upstream.
            pix_if.pix_req <= (state != S_IDLE) && (fifo_used <= REQ_LVL);

            case (state)
                S_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (enable) state <= S_PREFILL;
                end
                S_PREFILL: begin
                    if (fifo_used >= PF_LVL) state <= S_RUN;
                end
                S_RUN: begin
                    if (last_pix) begin
                        h_cnt <= '0;
                        v_cnt <= '0;
                        if (!enable) state <= S_IDLE;
                    end else if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= v_cnt + VW'(1);
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Video bus trails the counters by one cycle.
            vid_de      <= running && active;
            vid_hsync   <= (running && hs_act) ? HS_POL : ~HS_POL;
            vid_vsync   <= (running && vs_act) ? VS_POL : ~VS_POL;
            frame_start <= running && active && (h_cnt == '0) && (v_cnt == '0);
            if (running && active) begin
                vid_data <= empty ? UF_COLOR : mem[rd_ptr];
                if (empty) underflow <= 1'b1;
            end else begin
                vid_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_hdmi_video_timing_gen
// Small raster (8/2/2/2 x 4/1/1/1), 16-entry FIFO. A frame-position / queue
// reference model predicts every registered output each cycle; upstream is a
// jittery responder, a starving source or a flooding source.
// ---------------------------------------------------------------------------
module tb_hdmi_video_timing_gen;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DEPTH = 16, MARGIN = 4, PRE = 8;
    localparam bit HPOL = 1'b1, VPOL = 1'b1;
    localparam logic [23:0] UF = 24'hFF00FF;

    localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2;

    logic        tx_clock = 1'b0;
    logic        tx_rst_n = 1'b0;
    logic        enable   = 1'b0;
    logic [23:0] vid_data;
    logic        vid_de, vid_hsync, vid_vsync, frame_start, underflow, overflow;

    hdmi_video_timing_gen_if pix_if ();

    hdmi_video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HPOL), .VS_POL(VPOL),
        .FIFO_DEPTH(DEPTH), .REQ_MARGIN(MARGIN), .PREFILL(PRE), .UF_COLOR(UF)
    ) u_dut (
        .tx_clock   (tx_clock),
        .tx_rst_n   (tx_rst_n),
        .enable     (enable),
        .pix_if     (pix_if),
        .vid_data   (vid_data),
        .vid_de     (vid_de),
        .vid_hsync  (vid_hsync),
        .vid_vsync  (vid_vsync),
        .frame_start(frame_start),
        .underflow  (underflow),
        .overflow   (overflow)
    );

    always #5 tx_clock = ~tx_clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode = M_IDLE;
    int          m_pos  = 0;
    logic [23:0] m_q[$];
    logic [23:0] e_data;
    logic        e_req, e_de, e_hs, e_vs, e_fs, e_uf, e_ov;

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_q.delete();
        e_data = '0; e_req = 0; e_de = 0; e_hs = !HPOL; e_vs = !VPOL;
        e_fs = 0; e_uf = 0; e_ov = 0;
    endtask

    // One clock edge, using the inputs the bench is presenting at that edge.
    task automatic model_edge();
        int sz, h, v;
        bit full_b, act;
        sz = m_q.size();
        full_b = (sz >= DEPTH);
        if (m_mode == M_IDLE) begin
            e_req = 0; e_de = 0; e_hs = !HPOL; e_vs = !VPOL; e_fs = 0; e_data = '0;
            if (enable) m_mode = M_PRE;
            return;
        end
        e_req = (sz <= DEPTH - MARGIN);
        if (pix_if.pix_valid && full_b) e_ov = 1;
        if (m_mode == M_RUN) begin
            h = m_pos % HT;
            v = m_pos / HT;
            act  = (h < HA) && (v < VA);
            e_de = act;
            e_hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
            e_vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
            e_fs = (m_pos == 0);
            if (act) begin
                if (sz > 0) e_data = m_q.pop_front();
                else begin e_data = UF; e_uf = 1; end
            end else e_data = '0;
        end else begin
            e_de = 0; e_hs = !HPOL; e_vs = !VPOL; e_fs = 0; e_data = '0;
        end
        if (pix_if.pix_valid && !full_b) m_q.push_back(pix_if.pix_data);
        if (m_mode == M_PRE) begin
            if (sz >= PRE) begin m_mode = M_RUN; m_pos = 0; end
        end else if (m_pos == FRAME - 1) begin
            if (!enable) begin m_mode = M_IDLE; m_q.delete(); end
            m_pos = 0;
        end else m_pos++;
    endtask

    // ---------------- upstream + cycle driver ----------------
    int          up_mode   = 0;   // 0 respond to requests, 1 starve, 2 flood
    int          fixed_lat = 2;   // <0 : random 0..3
    bit          rnd_data  = 0;
    int          cyc       = 0;
    int          due[$];
    logic [23:0] k         = '0;
    bit          first_chk = 0;
    bit          de_track  = 0;
    int          de_cnt    = 0;
    int          fs_seen   = 0;

    task automatic next_pixel();
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = rnd_data ? 24'($urandom) : k;
        k++;
    endtask

    task automatic tick();
        @(posedge tx_clock);
        if (tx_rst_n) model_edge();
        #1;
        cyc++;
        chk("pix_req",     32'(pix_if.pix_req), 32'(e_req));
        chk("vid_de",      32'(vid_de),         32'(e_de));
        chk("vid_hsync",   32'(vid_hsync),      32'(e_hs));
        chk("vid_vsync",   32'(vid_vsync),      32'(e_vs));
        chk("frame_start", 32'(frame_start),    32'(e_fs));
        chk("vid_data",    32'(vid_data),       32'(e_data));
        chk("underflow",   32'(underflow),      32'(e_uf));
        chk("overflow",    32'(overflow),       32'(e_ov));
        if (first_chk && vid_de) begin
            chk("first_de_fs",   32'(frame_start), 32'd1);
            chk("first_de_data", 32'(vid_data),    32'd0);
            first_chk = 0;
        end
        if (frame_start) begin
            fs_seen++;
            if (de_track) chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
            de_cnt = 0;
            de_track = 1;
        end
        if (vid_de) de_cnt++;
        // drive next cycle's upstream inputs
        pix_if.pix_valid = 1'b0;
        case (up_mode)
            0: begin
                if (pix_if.pix_req)
                    due.push_back(cyc + ((fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat));
                if (due.size() > 0 && due[0] <= cyc) begin
                    void'(due.pop_front());
                    next_pixel();
                end
            end
            2: next_pixel();
            default: due.delete();
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = '0;
        model_reset();
        run(3);
        tx_rst_n = 1'b1;
        run(3);

        // 1: steady 2-cycle responder, pixels 0,1,2,...
        first_chk = 1;
        enable = 1'b1;
        run(2 * FRAME + 30);
        chk("t1_first_seen", 32'(first_chk), 32'd0);

        // random latency and random colours
        fixed_lat = -1;
        rnd_data  = 1;
        run(300);

        // 2: starve
        up_mode = 1;
        run(150);
        chk("t2_underflow", 32'(underflow), 32'd1);
        up_mode = 0;
        run(100);
        chk("t2_uf_sticky", 32'(underflow), 32'd1);

        // 3: flood regardless of pix_req
        up_mode = 2;
        run(100);
        chk("t3_overflow", 32'(overflow), 32'd1);
        up_mode = 0;
        due.delete();
        run(60);

        // 4: drop enable mid-frame
        guard = 0;
        while (!(m_mode == M_RUN && m_pos == 30) && guard < 400) begin tick(); guard++; end
        chk("t4_reach_mid", 32'(guard < 400), 32'd1);
        enable = 1'b0;
        guard = 0;
        while (m_mode != M_IDLE && guard < 2 * FRAME) begin tick(); guard++; end
        chk("t4_reach_idle", 32'(m_mode == M_IDLE), 32'd1);
        up_mode = 2;
        run(6);
        chk("t4_idle_req", 32'(pix_if.pix_req), 32'd0);
        chk("t4_idle_de",  32'(vid_de),         32'd0);
        chk("t4_idle_hs",  32'(vid_hsync),      32'(!HPOL));
        up_mode = 0;
        due.delete();
        fs_seen = 0;
        enable = 1'b1;
        run(FRAME + 40);
        chk("t4_restart", 32'(fs_seen > 0), 32'd1);

        // 5: asynchronous reset mid-line
        guard = 0;
        while (!(m_mode == M_RUN && (m_pos % HT) == 3) && guard < 400) begin tick(); guard++; end
        #2;
        tx_rst_n = 1'b0;
        #1;
        chk("t5_data",  32'(vid_data),       32'd0);
        chk("t5_de",    32'(vid_de),         32'd0);
        chk("t5_hs",    32'(vid_hsync),      32'(!HPOL));
        chk("t5_vs",    32'(vid_vsync),      32'(!VPOL));
        chk("t5_fs",    32'(frame_start),    32'd0);
        chk("t5_req",   32'(pix_if.pix_req), 32'd0);
        chk("t5_uf",    32'(underflow),      32'd0);
        chk("t5_ov",    32'(overflow),       32'd0);
        model_reset();
        de_track = 0;
        due.delete();
        run(3);
        tx_rst_n = 1'b1;
        fs_seen = 0;
        run(FRAME + 40);
        chk("t5_restart", 32'(fs_seen > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
